// File: rtl/alu_ctrl.sv
// Initiator for the registered 8-bit alu: accepts one 6502-level op per request,
// drives the alu, captures its registered result and maintains the N,V,Z,C status.
`timescale 1ns/1ps

module alu_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_wb,
    output logic [3:0] flags,
    input  logic       flag_load,
    input  logic [3:0] flag_in,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_mode,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_CMP = 4'd5,
        OP_ASL = 4'd6,
        OP_ROL = 4'd7,
        OP_LSR = 4'd8,
        OP_ROR = 4'd9,
        OP_INC = 4'd10,
        OP_DEC = 4'd11,
        OP_BIT = 4'd12
    } op_t;

    localparam logic [4:0] MODE_ADD  = 5'd0;
    localparam logic [4:0] MODE_AND  = 5'd1;
    localparam logic [4:0] MODE_OR   = 5'd2;
    localparam logic [4:0] MODE_EOR  = 5'd3;
    localparam logic [4:0] MODE_SR   = 5'd4;
    localparam logic [4:0] MODE_PASS = 5'd5;

    localparam logic [7:0] LAT_INIT = 8'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] latCnt_q, latCnt_d;
    op_t        op_q;
    logic       coldCarry_q;
    logic [7:0] aluA_q, aluA_d;
    logic [7:0] aluB_q, aluB_d;
    logic [4:0] aluMode_q, aluMode_d;
    logic       aluCin_q, aluCin_d;
    logic [7:0] respData_q, respData_d;
    logic       respWb_q, respWb_d;
    logic [3:0] flags_q, flags_d;

    logic       accept;
    logic       capture;
    logic [7:0] capData;
    logic       capWb;
    logic       capN, capV, capZ, capC;
    logic       updNZ;
    logic       addOverflow;

    assign accept  = (state_q == IDLE) && req_valid;
    assign capture = (state_q == CAPT);

    // ISSUE lasts ALU_LAT cycles so CAPT lines up with the alu's registered output.
    always_comb begin
        state_d  = state_q;
        latCnt_d = latCnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ISSUE;
                    latCnt_d = LAT_INIT;
                end
            end
            ISSUE: begin
                if (latCnt_q == 8'd0) begin
                    state_d = CAPT;
                end else begin
                    latCnt_d = latCnt_q - 8'd1;
                end
            end
            CAPT: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            latCnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
        end
    end

    // Operand/mode mapping at acceptance; the carry used is the one held before this edge.
    always_comb begin
        aluA_d    = req_a;
        aluB_d    = 8'h00;
        aluMode_d = MODE_PASS;
        aluCin_d  = 1'b0;
        case (op_t'(req_op))
            OP_ADC: begin aluB_d = req_b;  aluMode_d = MODE_ADD; aluCin_d = flags_q[0]; end
            OP_SBC: begin aluB_d = ~req_b; aluMode_d = MODE_ADD; aluCin_d = flags_q[0]; end
            OP_CMP: begin aluB_d = ~req_b; aluMode_d = MODE_ADD; aluCin_d = 1'b1;       end
            OP_INC: begin aluB_d = 8'h01;  aluMode_d = MODE_ADD; end
            OP_DEC: begin aluB_d = 8'hFF;  aluMode_d = MODE_ADD; end
            OP_AND: begin aluB_d = req_b;  aluMode_d = MODE_AND; end
            OP_BIT: begin aluB_d = req_b;  aluMode_d = MODE_AND; end
            OP_ORA: begin aluB_d = req_b;  aluMode_d = MODE_OR;  end
            OP_EOR: begin aluB_d = req_b;  aluMode_d = MODE_EOR; end
            OP_ASL: begin aluMode_d = MODE_SR; end
            OP_ROL: begin aluMode_d = MODE_SR; aluCin_d = flags_q[0]; end
            default: begin aluMode_d = MODE_PASS; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_ADC;
            coldCarry_q <= 1'b0;
            aluA_q      <= 8'h00;
            aluB_q      <= 8'h00;
            aluMode_q   <= MODE_ADD;
            aluCin_q    <= 1'b0;
        end else if (accept) begin
            op_q        <= op_t'(req_op);
            coldCarry_q <= flags_q[0];
            aluA_q      <= aluA_d;
            aluB_q      <= aluB_d;
            aluMode_q   <= aluMode_d;
            aluCin_q    <= aluCin_d;
        end
    end

    // Overflow is derived from the operands actually presented; the alu's own is ignored.
    assign addOverflow = (aluA_q[7] == aluB_q[7]) && (alu_out[7] != aluA_q[7]);

    always_comb begin
        capData = alu_out;
        capWb   = 1'b1;
        {capN, capV, capZ, capC} = flags_q;
        updNZ   = 1'b1;
        case (op_q)
            OP_ADC, OP_SBC: begin capC = alu_carry_out; capV = addOverflow; end
            OP_CMP: begin capC = alu_carry_out; capWb = 1'b0; end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin end
            OP_ASL: capC = alu_carry_out;
            OP_ROL: begin capData = {alu_out[7:1], coldCarry_q}; capC = alu_carry_out; end
            OP_LSR: begin capData = {1'b0, alu_out[7:1]};        capC = alu_out[0];    end
            OP_ROR: begin capData = {coldCarry_q, alu_out[7:1]}; capC = alu_out[0];    end
            OP_BIT: begin
                updNZ = 1'b0;
                capZ  = (alu_out == 8'h00);
                capN  = aluB_q[7];
                capV  = aluB_q[6];
                capWb = 1'b0;
            end
            default: begin updNZ = 1'b0; capWb = 1'b0; end
        endcase
        if (updNZ) begin
            capN = capData[7];
            capZ = (capData == 8'h00);
        end
    end

    // On the capture edge the op's flag update takes priority and any flag_load is dropped.
    always_comb begin
        respData_d = respData_q;
        respWb_d   = respWb_q;
        flags_d    = flags_q;
        if (capture) begin
            respData_d = capData;
            respWb_d   = capWb;
            flags_d    = {capN, capV, capZ, capC};
        end else if (flag_load) begin
            flags_d    = flag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respData_q <= 8'h00;
            respWb_q   <= 1'b0;
            flags_q    <= 4'h0;
        end else begin
            respData_q <= respData_d;
            respWb_q   <= respWb_d;
            flags_q    <= flags_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_data    = respData_q;
    assign resp_wb      = respWb_q;
    assign flags        = flags_q;
    assign alu_a        = aluA_q;
    assign alu_b        = aluB_q;
    assign alu_mode     = aluMode_q;
    assign alu_carry_in = aluCin_q;

endmodule
